// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : EX-stage initiator for the RV32M multi-cycle multiplier and
//               divider. Issues start pulses, holds operands, stalls the
//               pipeline, resolves divide-by-zero / signed overflow locally
//               and guards each wait with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            err_o,
  output logic            div_start_o,
  output logic [1:0]      div_func_o,
  output logic [XLEN-1:0] div_operand_a_o,
  output logic [XLEN-1:0] div_operand_b_o,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            div_done_i,
  output logic            mul_start_o,
  output logic [1:0]      mul_func_o,
  output logic [XLEN-1:0] mul_operand_a_o,
  output logic [XLEN-1:0] mul_operand_b_o,
  input  logic [XLEN-1:0] mul_result_i,
  input  logic            mul_done_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WDOG_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  C_ALL_ONES  = '1;
  localparam logic [XLEN-1:0]  C_INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_div_a;
  logic [XLEN-1:0] r_div_b;
  logic [1:0]      r_div_func;
  logic [XLEN-1:0] r_mul_a;
  logic [XLEN-1:0] r_mul_b;
  logic [1:0]      r_mul_func;
  logic [XLEN-1:0] r_result;
  logic            r_err;
  logic            r_unit_div;   // outstanding op belongs to the divider
  logic [CNT_W-1:0] r_wdog;

  logic            w_accept;
  logic            w_is_div;
  logic            w_div_by_zero;
  logic            w_div_ovf;
  logic            w_div_fast;
  logic            w_div_start;
  logic            w_mul_start;
  logic [XLEN-1:0] w_fast_result;
  logic            w_unit_done;
  logic [XLEN-1:0] w_unit_result;
  logic            w_wdog_expired;

  // Acceptance is gated by reset so nothing leaks out combinationally while held in reset.
  assign w_accept      = rst_ni & (r_state == S_IDLE) & valid_i & ~flush_i;
  assign w_is_div      = funct3_i[2];
  assign w_div_by_zero = (operand_b_i == '0);
  // Only the signed forms (DIV/REM, funct3[0]=0) can overflow.
  assign w_div_ovf     = ~funct3_i[0] & (operand_a_i == C_INT_MIN) &
                         (operand_b_i == C_ALL_ONES);
  assign w_div_fast    = w_is_div & (w_div_by_zero | w_div_ovf);
  assign w_div_start   = w_accept & w_is_div & ~w_div_fast;
  assign w_mul_start   = w_accept & ~w_is_div;

  // funct3[1] selects remainder over quotient.
  assign w_fast_result = w_div_by_zero ? (funct3_i[1] ? operand_a_i : C_ALL_ONES)
                                       : (funct3_i[1] ? '0 : C_INT_MIN);

  assign w_unit_done    = r_unit_div ? div_done_i : mul_done_i;
  assign w_unit_result  = r_unit_div ? div_result_i : mul_result_i;
  assign w_wdog_expired = (r_wdog == C_WDOG_LAST);

  // In the accept cycle the units see the live inputs; afterwards the captured copy.
  assign div_start_o     = w_div_start;
  assign div_func_o      = w_div_start ? funct3_i[1:0] : r_div_func;
  assign div_operand_a_o = w_div_start ? operand_a_i   : r_div_a;
  assign div_operand_b_o = w_div_start ? operand_b_i   : r_div_b;
  assign mul_start_o     = w_mul_start;
  assign mul_func_o      = w_mul_start ? funct3_i[1:0] : r_mul_func;
  assign mul_operand_a_o = w_mul_start ? operand_a_i   : r_mul_a;
  assign mul_operand_b_o = w_mul_start ? operand_b_i   : r_mul_b;

  assign result_o       = r_result;
  assign result_valid_o = (r_state == S_DONE) & ~flush_i;
  assign err_o          = r_err;

  // Pipeline stall: held while a unit owns EX, released on flush, and in DRAIN only for a waiting request.
  always_comb begin
    stall_o = 1'b0;
    unique case (r_state)
      S_IDLE:                 stall_o = w_accept;
      S_MUL_WAIT, S_DIV_WAIT: stall_o = ~flush_i;
      S_DRAIN:                stall_o = valid_i;
      S_DONE:                 stall_o = 1'b0;
      default:                stall_o = 1'b0;
    endcase
  end

  // Control FSM with operand capture, result latch and watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_div_a    <= '0;
      r_div_b    <= '0;
      r_div_func <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_func <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_unit_div <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (w_accept) begin
            r_unit_div <= w_is_div;
            if (w_div_fast) begin
              r_result <= w_fast_result;
              r_state  <= S_DONE;
            end else if (w_is_div) begin
              r_div_a    <= operand_a_i;
              r_div_b    <= operand_b_i;
              r_div_func <= funct3_i[1:0];
              r_state    <= S_DIV_WAIT;
            end else begin
              r_mul_a    <= operand_a_i;
              r_mul_b    <= operand_b_i;
              r_mul_func <= funct3_i[1:0];
              r_state    <= S_MUL_WAIT;
            end
          end
        end
        S_MUL_WAIT, S_DIV_WAIT: begin
          if (w_unit_done) begin
            // A completion racing a flush is simply dropped.
            r_wdog <= '0;
            if (flush_i) begin
              r_state <= S_IDLE;
            end else begin
              r_result <= w_unit_result;
              r_state  <= S_DONE;
            end
          end else if (w_wdog_expired) begin
            r_wdog <= '0;
            r_err  <= 1'b1;
            if (flush_i) begin
              r_state <= S_IDLE;
            end else begin
              r_result <= '0;
              r_state  <= S_DONE;
            end
          end else if (flush_i) begin
            r_wdog  <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_wdog <= r_wdog + C_WDOG_ONE;
          end
        end
        S_DRAIN: begin
          if (w_unit_done) begin
            r_wdog  <= '0;
            r_state <= S_IDLE;
          end else if (w_wdog_expired) begin
            r_wdog  <= '0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + C_WDOG_ONE;
          end
        end
        S_DONE: begin
          r_wdog  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_wdog  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl with behavioural divider
//               and multiplier models and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic            flush_i;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;
  logic            err_o;
  logic            div_start_o;
  logic [1:0]      div_func_o;
  logic [XLEN-1:0] div_operand_a_o;
  logic [XLEN-1:0] div_operand_b_o;
  logic [XLEN-1:0] div_result_i;
  logic            div_done_i;
  logic            mul_start_o;
  logic [1:0]      mul_func_o;
  logic [XLEN-1:0] mul_operand_a_o;
  logic [XLEN-1:0] mul_operand_b_o;
  logic [XLEN-1:0] mul_result_i;
  logic            mul_done_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  int   div_lat = 2;
  int   mul_lat = 2;
  int   div_cnt = 0;
  int   mul_cnt = 0;
  logic stray_div = 1'b0;
  logic stray_mul = 1'b0;

  muldiv_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .funct3_i(funct3_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
    .stall_o(stall_o), .result_o(result_o), .result_valid_o(result_valid_o),
    .err_o(err_o), .div_start_o(div_start_o), .div_func_o(div_func_o),
    .div_operand_a_o(div_operand_a_o), .div_operand_b_o(div_operand_b_o),
    .div_result_i(div_result_i), .div_done_i(div_done_i),
    .mul_start_o(mul_start_o), .mul_func_o(mul_func_o),
    .mul_operand_a_o(mul_operand_a_o), .mul_operand_b_o(mul_operand_b_o),
    .mul_result_i(mul_result_i), .mul_done_i(mul_done_i)
  );

  always #5 clk_i = ~clk_i;

  // RV32M reference divide (quotient or remainder by f[1], unsigned by f[0]).
  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  // RV32M reference multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] za;
    logic [63:0] zb;
    logic [63:0] p;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    za = {32'd0, a};       zb = {32'd0, b};
    case (f)
      2'b00:   begin p = za * zb; return p[31:0];  end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * zb; return p[63:32]; end
      default: begin p = za * zb; return p[63:32]; end
    endcase
  endfunction

  // Unit models: done after a programmable latency (0 = never), result from the live held operands.
  always @(posedge clk_i) begin
    if (div_start_o) div_cnt <= div_lat;
    else if (div_cnt > 0) div_cnt <= div_cnt - 1;
    if (mul_start_o) mul_cnt <= mul_lat;
    else if (mul_cnt > 0) mul_cnt <= mul_cnt - 1;
  end
  assign div_done_i   = (div_cnt == 1) | stray_div;
  assign mul_done_i   = (mul_cnt == 1) | stray_mul;
  assign div_result_i = ref_div(div_func_o, div_operand_a_o, div_operand_b_o);
  assign mul_result_i = ref_mul(mul_func_o, mul_operand_a_o, mul_operand_b_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result strobe must match the oldest expected value.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && result_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_result", result_valid_o, 1'b0);
      else check("result", result_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for the result strobe; checks stall/hold in the cycles before it.
  task automatic wait_result(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input int exp_lat, input logic exp_err);
    int lat;
    for (lat = 1; lat <= 200; lat++) begin
      @(negedge clk_i);
      if (result_valid_o) break;
      check({tag, "_stall_wait"}, stall_o, 1'b1);
      check({tag, "_err_wait"}, err_o, 1'b0);
      if (f[2]) begin
        check({tag, "_nostart"}, div_start_o, 1'b0);
        check({tag, "_hold_ab"}, {div_operand_a_o, div_operand_b_o}, {a, b});
        check({tag, "_hold_f"}, div_func_o, f[1:0]);
      end else begin
        check({tag, "_nostart"}, mul_start_o, 1'b0);
        check({tag, "_hold_ab"}, {mul_operand_a_o, mul_operand_b_o}, {a, b});
        check({tag, "_hold_f"}, mul_func_o, f[1:0]);
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_done"}, stall_o, 1'b0);
    check({tag, "_err"}, err_o, exp_err);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input logic exp_err);
    logic fast;
    fast = (exp_lat == 1);
    tick();
    valid_i = 1'b1; funct3_i = f; operand_a_i = a; operand_b_i = b;
    @(negedge clk_i);
    check({tag, "_stall_acc"}, stall_o, 1'b1);
    if (f[2]) begin
      check({tag, "_div_start"}, div_start_o, !fast);
      check({tag, "_mul_start"}, mul_start_o, 1'b0);
      if (!fast) check({tag, "_div_ops"}, {div_func_o, div_operand_a_o, div_operand_b_o}, {f[1:0], a, b});
    end else begin
      check({tag, "_mul_start"}, mul_start_o, 1'b1);
      check({tag, "_div_start"}, div_start_o, 1'b0);
      check({tag, "_mul_ops"}, {mul_func_o, mul_operand_a_o, mul_operand_b_o}, {f[1:0], a, b});
    end
    exp_q.push_back(exp);
    tick();
    valid_i = 1'b0;
    wait_result(tag, f, a, b, exp_lat, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni = 1'b0; valid_i = 1'b0; funct3_i = '0; operand_a_i = '0; operand_b_i = '0; flush_i = 1'b0;
    @(negedge clk_i);
    check("rst_outs", {stall_o, result_valid_o, err_o, div_start_o, mul_start_o}, 5'd0);
    check("rst_data", {result_o, div_func_o, div_operand_a_o, div_operand_b_o,
                       mul_func_o, mul_operand_a_o, mul_operand_b_o}, '0);
    tick(); tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_stall", stall_o, 1'b0);

    // Normal divider path, 2-cycle unit.
    run_op("divu_15_7",  3'b101, 32'd15,          32'd7,          32'd2,          3, 1'b0);
    run_op("rem_m15_5",  3'b110, 32'hFFFF_FFF1,   32'd5,          32'd0,          3, 1'b0);
    run_op("div_m15_5",  3'b100, 32'hFFFF_FFF1,   32'd5,          32'hFFFF_FFFD,  3, 1'b0);
    // Local fast paths.
    run_op("div_by0",    3'b100, 32'd7,           32'd0,          32'hFFFF_FFFF,  1, 1'b0);
    run_op("remu_by0",   3'b111, 32'd7,           32'd0,          32'd7,          1, 1'b0);
    run_op("div_ovf",    3'b100, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  1, 1'b0);
    run_op("rem_ovf",    3'b110, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,          1, 1'b0);
    run_op("divu_noovf", 3'b101, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,          3, 1'b0);

    // Flush while idle: no accept.
    tick();
    valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b101; operand_a_i = 32'd4; operand_b_i = 32'd2;
    @(negedge clk_i);
    check("idle_flush_stall", stall_o, 1'b0);
    check("idle_flush_start", div_start_o, 1'b0);
    tick();
    valid_i = 1'b0; flush_i = 1'b0;

    // Flush in DONE suppresses the strobe.
    tick();
    valid_i = 1'b1; funct3_i = 3'b100; operand_a_i = 32'd7; operand_b_i = 32'd0;
    tick();
    valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    check("done_flush_rv", result_valid_o, 1'b0);
    tick();
    flush_i = 1'b0;

    // Flush mid-divide, then a new request waits through DRAIN.
    div_lat = 4;
    tick();
    valid_i = 1'b1; funct3_i = 3'b100; operand_a_i = 32'd100; operand_b_i = 32'd7;
    @(negedge clk_i);
    check("fl_start", div_start_o, 1'b1);
    tick();
    valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    check("fl_stall_flush", stall_o, 1'b0);
    tick();
    flush_i = 1'b0; valid_i = 1'b1; funct3_i = 3'b101; operand_a_i = 32'd9; operand_b_i = 32'd3;
    @(negedge clk_i);
    check("fl_drain_stall", stall_o, 1'b1);
    check("fl_drain_nostart", div_start_o, 1'b0);
    n = 0;
    while (!div_start_o && n < 50) begin
      @(negedge clk_i);
      n++;
      check("fl_wait_stall", stall_o, 1'b1);
    end
    check("fl_accept_delay", n, 3);
    check("fl_new_ops", {div_func_o, div_operand_a_o, div_operand_b_o}, {2'b01, 32'd9, 32'd3});
    exp_q.push_back(32'd3);
    tick();
    valid_i = 1'b0;
    wait_result("fl_divu_9_3", 3'b101, 32'd9, 32'd3, 5, 1'b0);
    div_lat = 2;

    // Watchdog on a divider that never finishes.
    div_lat = 0;
    run_op("wdog", 3'b100, 32'd10, 32'd3, 32'd0, TO + 1, 1'b1);
    @(negedge clk_i);
    check("wdog_err_clear", err_o, 1'b0);
    check("wdog_idle_stall", stall_o, 1'b0);

    // Asynchronous reset mid-wait.
    tick();
    valid_i = 1'b1; funct3_i = 3'b100; operand_a_i = 32'd50; operand_b_i = 32'd6;
    tick();
    valid_i = 1'b0;
    tick();
    #2 rst_ni = 1'b0;
    #1;
    check("arst_outs", {stall_o, result_valid_o, err_o, div_start_o, mul_start_o}, 5'd0);
    check("arst_data", {result_o, div_func_o, div_operand_a_o, div_operand_b_o,
                        mul_func_o, mul_operand_a_o, mul_operand_b_o}, '0);
    tick();
    rst_ni = 1'b1;
    div_lat = 2;

    // Multiplier path with a stray divider done throughout.
    stray_div = 1'b1;
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'd2, ref_mul(2'b11, 32'hFFFF_FFFF, 32'd2), 3, 1'b0);
    stray_div = 1'b0;
    run_op("mul",    3'b000, 32'hFFFF_FFFD, 32'd5, ref_mul(2'b00, 32'hFFFF_FFFD, 32'd5), 3, 1'b0);
    run_op("mulh",   3'b001, 32'hFFFF_FFFD, 32'd5, ref_mul(2'b01, 32'hFFFF_FFFD, 32'd5), 3, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0);

    // Stray completions in IDLE are ignored.
    tick();
    stray_div = 1'b1; stray_mul = 1'b1;
    tick(); tick();
    stray_div = 1'b0; stray_mul = 1'b0;
    @(negedge clk_i);
    check("stray_idle_stall", stall_o, 1'b0);

    tick(); tick();
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
EX-stage initiator for the RV32M multi-cycle units. It decodes the M-extension funct3 and issues one-cycle start pulses to the divider and the multiplier. It holds their operands stable, stalls the pipeline until the unit's done, and presents a one-cycle result to EX/MEM. Division-by-zero and signed overflow are resolved locally without invoking the divider. A watchdog guards against a unit that never completes.

Parameters:
XLEN, 32, operand/result width
TIMEOUT_CYCLES, 64, max cycles in a wait state before abort (≥4)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
valid_i  in  1  EX holds an M-extension instruction
funct3_i  in  3  000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
operand_a_i  in  XLEN  rs1 value
operand_b_i  in  XLEN  rs2 value
flush_i  in  1  kill the EX instruction (branch/trap)
stall_o  out  1  freeze IF/ID/EX
result_o  out  XLEN  result, valid with result_valid_o
result_valid_o  out  1  one-cycle result strobe
err_o  out  1  one-cycle watchdog-timeout strobe
div_start_o  out  1  divider start pulse
div_func_o  out  2  funct3[1:0] (00 DIV,01 DIVU,10 REM,11 REMU)
div_operand_a_o  out  XLEN  registered dividend
div_operand_b_o  out  XLEN  registered divisor
div_result_i  in  XLEN  divider result
div_done_i  in  1  divider done
mul_start_o  out  1  multiplier start pulse
mul_func_o  out  2  funct3[1:0]
mul_operand_a_o  out  XLEN  registered operand
mul_operand_b_o  out  XLEN  registered operand
mul_result_i  in  XLEN  multiplier result
mul_done_i  in  1  multiplier done

Behaviour:
- Reset (async, any state): state IDLE. All outputs 0, including the operand/func registers. The watchdog counter is 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN, DONE.
- IDLE with valid_i=1 and flush_i=0 (accept):
  - Register a, b and funct3.
  - stall_o=1 combinationally in this cycle.
- Divider fast paths at accept (no start pulse, next state DONE):
  - b==0: quotient 0xFFFFFFFF; remainder a (signed and unsigned).
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF: quotient 0x80000000; remainder 0.
- Normal divider op: div_start_o=1 for the accept cycle only, with operands/func driven combinationally from the inputs. Next state DIV_WAIT.
- MUL class: mul_start_o=1 likewise. Next state MUL_WAIT.
- Operand hold: the operand/func outputs keep the captured values from accept until done is sampled. The divider computes in its second cycle from live operands, so the values must not change.
- In MUL_WAIT/DIV_WAIT: stall_o=1 and the watchdog increments.
  - The matching done_i latches the result into result_o. Next state DONE.
  - Non-matching done_i is ignored.
- DONE: result_valid_o=1, stall_o=0, then IDLE. valid_i is ignored in DONE; the pipeline advances at this edge.
- result_o holds its last value; it is meaningful only with result_valid_o.
- flush_i:
  - In IDLE: no accept.
  - In a wait state: go to DRAIN, stall_o=0, no result.
  - In DONE: result_valid_o is suppressed.
- DRAIN: wait for the pending unit's done, discard it, go to IDLE.
  - stall_o = valid_i (a new request waits).
  - The watchdog still runs.
- done_i and flush_i in the same wait cycle: discard, go to IDLE.
- Watchdog: when the counter reaches TIMEOUT_CYCLES-1 in any wait/DRAIN state:
  - err_o=1 for one cycle.
  - From a wait state: result_o=0, go to DONE. From DRAIN: go to IDLE.
  - The counter clears on every state exit.
- Stray done_i in IDLE/DONE is ignored.

Test Plan:
- Reset, then DIVU a=15, b=7 against a 2-cycle-latency divider model -> div_start_o pulses on the accept cycle (cycle 0) only; stall_o high in cycles 0–2; result_valid_o with result_o=2 in cycle 3; operands stable in cycles 0–2.
- REM a=0xFFFFFFF1 (-15), b=5 -> result_o=0; DIV a=-15, b=5 -> 0xFFFFFFFD.
- DIV a=7, b=0 -> no div_start_o; result_valid_o in cycle 1, result_o=0xFFFFFFFF. REMU a=7, b=0 -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, no start.
- DIV accepted, flush_i in cycle 1, new DIVU 9/3 presented in cycle 2 -> first result discarded, no result_valid_o for it; stall_o held while DRAIN waits; second op accepted after IDLE and returns 3.
- Divider model never asserts done -> err_o pulse after TIMEOUT_CYCLES wait cycles, result_valid_o with 0, back to IDLE; assert rst_ni low mid-DIV_WAIT -> all outputs 0 immediately.
- MULHU 0xFFFFFFFF×2 with the multiplier model -> mul_start_o pulse, mul_func_o=11, result_o = model value; a concurrent stray div_done_i is ignored.
